// File: rtl/tile_controller.sv
// tile_controller
//   Single-tile Winograd F(4x4, 3x3) engine. Latches one 3x3 kernel and one
//   6x6 input tile on start, then produces the 4x4 valid 2-D correlation
//   Y[r][c] = sum_{i,j} tile[r+i][c+j] * kernel[i][j] via Winograd transforms.
//   The kernel transform uses G' = 24*G, so U' = 576*U. The output transform
//   divides by 576, and this division is exact. All internal arithmetic is
//   signed 64-bit.
//
//   Pipeline (one state per cycle): IDLE -> XFORM -> MULT -> OTRANS -> DONE.
//   With start captured at edge E0, result_out updates at E3 and done is high
//   from E4 to E5.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : job request, sampled only in IDLE
//   kernel_in  : [0:2][0:2] x 16-bit signed kernel g, row-major
//   tile_in    : [0:5][0:5] x 16-bit signed input tile d
//   result_out : [0:3][0:3] x 16-bit registered result Y
//   done       : registered one-cycle completion pulse
//
// Configuration
//   TILE_CTRL_SAT_EN : when defined, each Y saturates to [-32768, 32767];
//                      otherwise Y is truncated to its low 16 bits.

module tile_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] kernel_in  [0:2][0:2],
  input  logic [15:0] tile_in    [0:5][0:5],
  output logic [15:0] result_out [0:3][0:3],
  output logic        done
);

  typedef enum logic [2:0] {IDLE, XFORM, MULT, OTRANS, DONE} state_t;

  // G' = 24*G
  localparam int G_P [0:5][0:2] = '{
    '{ 6,  0,  0},
    '{-4, -4, -4},
    '{-4,  4, -4},
    '{ 1,  2,  4},
    '{ 1, -2,  4},
    '{ 0,  0, 24}
  };

  localparam int B_T [0:5][0:5] = '{
    '{4,  0, -5,  0, 1, 0},
    '{0, -4, -4,  1, 1, 0},
    '{0,  4, -4, -1, 1, 0},
    '{0, -2, -1,  2, 1, 0},
    '{0,  2, -1, -2, 1, 0},
    '{0,  4,  0, -5, 0, 1}
  };

  localparam int A_T [0:3][0:5] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  state_t state, state_nxt;
  logic   cap_en, xf_en, mul_en, out_en, done_nxt;

  logic [15:0]        g_q [0:2][0:2];
  logic [15:0]        d_q [0:5][0:5];
  logic signed [63:0] u_q [0:5][0:5];
  logic signed [63:0] v_q [0:5][0:5];
  logic signed [63:0] m_q [0:5][0:5];

  logic signed [63:0] gg    [0:5][0:2];
  logic signed [63:0] u_c   [0:5][0:5];
  logic signed [63:0] bd    [0:5][0:5];
  logic signed [63:0] v_c   [0:5][0:5];
  logic signed [63:0] am    [0:3][0:5];
  logic signed [63:0] y_sum [0:3][0:3];
  logic [15:0]        y_w   [0:3][0:3];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    xf_en     = 1'b0;
    mul_en    = 1'b0;
    out_en    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_en    = 1'b1;
          state_nxt = XFORM;
        end
      end
      XFORM: begin
        xf_en     = 1'b1;
        state_nxt = MULT;
      end
      MULT: begin
        mul_en    = 1'b1;
        state_nxt = OTRANS;
      end
      OTRANS: begin
        out_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------- kernel transform U' = G'gG'^T
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        gg[i][j] = '0;
        for (int unsigned k = 0; k < 3; k++)
          gg[i][j] += 64'(G_P[i][k]) * 64'($signed(g_q[k][j]));
      end
    end
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        u_c[i][j] = '0;
        for (int unsigned k = 0; k < 3; k++)
          u_c[i][j] += gg[i][k] * 64'(G_P[j][k]);
      end
    end
  end

  // --------------------------------------------- input transform V = B^T d B
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        bd[i][j] = '0;
        for (int unsigned k = 0; k < 6; k++)
          bd[i][j] += 64'(B_T[i][k]) * 64'($signed(d_q[k][j]));
      end
    end
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        v_c[i][j] = '0;
        for (int unsigned k = 0; k < 6; k++)
          v_c[i][j] += bd[i][k] * 64'(B_T[j][k]);
      end
    end
  end

  // ------------------------------------ output transform Y = A^T M A / 576
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        am[i][j] = '0;
        for (int unsigned k = 0; k < 6; k++)
          am[i][j] += 64'(A_T[i][k]) * m_q[k][j];
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        y_sum[i][j] = '0;
        for (int unsigned k = 0; k < 6; k++)
          y_sum[i][j] += am[i][k] * 64'(A_T[j][k]);
      end
    end
  end

  // Undo the 576 scale from G' and narrow to 16 bits.
`ifdef TILE_CTRL_SAT_EN
  always_comb begin
    logic signed [63:0] y_div;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        y_div = y_sum[i][j] / 64'sd576;
        if (y_div > 64'sd32767)
          y_w[i][j] = 16'h7FFF;
        else if (y_div < -64'sd32768)
          y_w[i][j] = 16'h8000;
        else
          y_w[i][j] = y_div[15:0];
      end
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned j = 0; j < 4; j++)
        y_w[i][j] = 16'(y_sum[i][j] / 64'sd576);
  end
`endif

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q        <= '{default: '0};
      d_q        <= '{default: '0};
      u_q        <= '{default: '0};
      v_q        <= '{default: '0};
      m_q        <= '{default: '0};
      result_out <= '{default: '0};
      done       <= 1'b0;
    end else begin
      done <= done_nxt;
      if (cap_en) begin
        g_q <= kernel_in;
        d_q <= tile_in;
      end
      if (xf_en) begin
        u_q <= u_c;
        v_q <= v_c;
      end
      if (mul_en) begin
        for (int unsigned i = 0; i < 6; i++)
          for (int unsigned j = 0; j < 6; j++)
            m_q[i][j] <= u_q[i][j] * v_q[i][j];
      end
      if (out_en)
        result_out <= y_w;
    end
  end

endmodule

// File: tb/tb_tile_controller.sv
// tb_tile_controller
//   Directed bench for tile_controller: hand-computed result tables, done
//   timing relative to the capture edge, start ignored while busy,
//   back-to-back acceptance, and reset abort during OTRANS.

module tb_tile_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] k   [0:2][0:2];
  logic [15:0] t   [0:5][0:5];
  logic [15:0] res [0:3][0:3];
  logic        done;

  logic [15:0] exp_y     [0:3][0:3];
  logic [15:0] exp_ident [0:3][0:3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tile_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .kernel_in  (k),
    .tile_in    (t),
    .result_out (res),
    .done       (done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("%s y[%0d][%0d]", tag, r, c), res[r][c], exp_y[r][c]);
  endtask

  task automatic fill(input logic [15:0] kv, input logic [15:0] tv);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        k[i][j] = kv;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = tv;
  endtask

  task automatic set_exp(input logic [15:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_y[r][c] = v;
  endtask

  task automatic load_ident();
    fill(16'd0, 16'd0);
    k[1][1] = 16'd1;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = 16'(6 * i + j + 1);
  endtask

  task automatic scramble();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        k[i][j] = 16'($urandom);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = 16'($urandom);
  endtask

  // One job from the current operands; operands are scrambled right after
  // capture, so the result must come from the latched copy.
  task automatic run_job(input string tag);
    start = 1'b1;
    tick();                                            // E0
    start = 1'b0;
    scramble();
    tick(); check({tag, " done@E1"}, {15'b0, done}, 16'd0);
    tick(); check({tag, " done@E2"}, {15'b0, done}, 16'd0);
    tick(); check({tag, " done@E3"}, {15'b0, done}, 16'd0);
    check_res(tag);
    tick(); check({tag, " done@E4"}, {15'b0, done}, 16'd1);
    tick(); check({tag, " done@E5"}, {15'b0, done}, 16'd0);
  endtask

  initial begin
    int ndone;

    exp_ident = '{
      '{16'd8,  16'd9,  16'd10, 16'd11},
      '{16'd14, 16'd15, 16'd16, 16'd17},
      '{16'd20, 16'd21, 16'd22, 16'd23},
      '{16'd26, 16'd27, 16'd28, 16'd29}
    };

    // Reset state
    fill(16'd0, 16'd0);
    tick();
    tick();
    check("reset done", {15'b0, done}, 16'd0);
    set_exp(16'd0);
    check_res("reset");
    rst_n = 1'b1;
    tick();

    // Identity kernel
    load_ident();
    exp_y = exp_ident;
    run_job("ident");

    // All ones
    fill(16'd1, 16'd1);
    set_exp(16'd9);
    run_job("ones");

    // Cross-shaped kernel on a mod-3 ramp tile
    fill(16'd0, 16'd0);
    k = '{'{16'd1, 16'd0, 16'd1}, '{16'd0, 16'd2, 16'd0}, '{16'd1, 16'd0, 16'd1}};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = 16'((i + j) % 3 + 1);
    exp_y = '{
      '{16'd15, 16'd9,  16'd12, 16'd15},
      '{16'd9,  16'd12, 16'd15, 16'd9 },
      '{16'd12, 16'd15, 16'd9,  16'd12},
      '{16'd15, 16'd9,  16'd12, 16'd15}
    };
    run_job("cross");

    // Negative centre tap
    fill(16'd0, 16'd5);
    k[1][1] = 16'hFFFF;
    set_exp(16'hFFFB);
    run_job("neg");

    // Full-scale operands: wrap vs saturate
    fill(16'h7FFF, 16'h7FFF);
`ifdef TILE_CTRL_SAT_EN
    set_exp(16'h7FFF);
`else
    set_exp(16'h0009);
`endif
    run_job("max");

    // start held high: second job captured at E5, done again at E9
    fill(16'd1, 16'd1);
    set_exp(16'd9);
    start = 1'b1;
    tick();                                            // E0
    load_ident();
    tick(); check("b2b done@E1", {15'b0, done}, 16'd0);
    tick();                                            // E2
    tick(); check_res("b2b first");                    // E3
    tick(); check("b2b done@E4", {15'b0, done}, 16'd1);
    tick(); check("b2b done@E5", {15'b0, done}, 16'd0); // E5: second capture
    start = 1'b0;
    scramble();
    tick();                                            // E6
    tick(); check_res("b2b hold");                     // E7
    tick();                                            // E8
    exp_y = exp_ident;
    check_res("b2b second");
    check("b2b done@E8", {15'b0, done}, 16'd0);
    tick(); check("b2b done@E9", {15'b0, done}, 16'd1);
    tick(); check("b2b done@E10", {15'b0, done}, 16'd0);

    // start during MULT is ignored
    fill(16'd0, 16'd5);
    k[1][1] = 16'hFFFF;
    set_exp(16'hFFFB);
    start = 1'b1;
    tick();                                            // E0
    start = 1'b0;
    tick();                                            // E1, now in MULT
    start = 1'b1;
    tick();                                            // E2
    start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done) ndone++;
    end
    check("busy start done count", 16'(ndone), 16'd1);
    check_res("busy start");

    // Reset during OTRANS aborts the job
    fill(16'd1, 16'd1);
    start = 1'b1;
    tick();                                            // E0
    start = 1'b0;
    tick();                                            // E1
    tick();                                            // E2, now in OTRANS
    rst_n = 1'b0;
    #1;
    set_exp(16'd0);
    check("abort done", {15'b0, done}, 16'd0);
    check_res("abort");
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (done) ndone++;
    end
    check("abort done count", 16'(ndone), 16'd0);
    check_res("abort hold");

    // FSM came back in IDLE: a fresh job runs with normal timing
    load_ident();
    exp_y = exp_ident;
    run_job("post-rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
